mem_req_arbiter: RTL
====================

# mem_req_arbiter

Sequences and shares the single cache-line RAM port between the instruction cache and the data cache. It accepts read-fill requests from both caches, plus an optional dirty-victim writeback from the data cache. It serialises them onto the memory with a fixed access latency, and returns the line with a one-cycle ready pulse to the winning cache. It sits between the L1 caches and `ram_memory`, replacing ad-hoc per-cycle request polling with an explicit FSM, latched requests and starvation-bounded priority.

## Interface

Parameters:
- `ADDR_W`, 20, line address width
- `LINE_W`, 128, cache line width
- `LAT`, 4, memory cycles per access phase (≥1)
- `STARVE_MAX`, 4, consecutive dcache grants tolerated while icache waits (≥1)

Ports:
- `clk`  in  1  single clock, all logic on rising edge
- `reset`  in  1  synchronous, active-high
- `icache_req`  in  1  icache fill request, level, held until `icache_ready`
- `icache_addr`  in  ADDR_W  icache fill line address
- `dcache_req`  in  1  dcache fill request, level, held until `dcache_ready`
- `dcache_addr`  in  ADDR_W  dcache fill line address
- `dcache_wb`  in  1  victim writeback required before the fill; qualified by `dcache_req`
- `dcache_wb_addr`  in  ADDR_W  victim line address
- `dcache_wb_data`  in  LINE_W  victim line data
- `mem_rdata`  in  LINE_W  RAM read data
- `mem_addr`  out  ADDR_W  RAM address
- `mem_rd`  out  1  RAM read phase active
- `mem_wr`  out  1  RAM write strobe
- `mem_wdata`  out  LINE_W  RAM write data
- `data_to_cache`  out  LINE_W  returned line, shared by both caches
- `icache_ready`  out  1  one-cycle pulse, `data_to_cache` valid for icache
- `dcache_ready`  out  1  one-cycle pulse, `data_to_cache` valid for dcache
- `dcache_wb_ack`  out  1  one-cycle pulse, victim written
- `busy`  out  1  high in any state other than IDLE

## Operation

- States:
  - IDLE: arbitrate.
  - WB: dcache writeback, LAT cycles.
  - RD: fill read, LAT cycles.
  - RESP: 1 cycle.
- IDLE transitions:
  - No request: stay in IDLE.
  - Grant dcache with `dcache_wb`=1: go to WB.
  - Any other grant: go to RD.
- Arbitration in IDLE:
  - A single requester wins.
  - If both request, dcache wins unless `starve_cnt == STARVE_MAX`, in which case icache wins.
- `starve_cnt`:
  - Increments on every dcache grant while `icache_req`=1, saturating at STARVE_MAX.
  - Clears on an icache grant.
  - Unchanged otherwise.
- At grant, the arbiter latches the requester id and all addresses and data. Input changes after the grant are ignored until the next IDLE.
- WB state:
  - `mem_addr` = latched wb address and `mem_wdata` = latched wb data, both held for all LAT cycles.
  - `mem_wr`=1 in the first WB cycle only.
  - `dcache_wb_ack`=1 in the last WB cycle.
  - Then go to RD.
- RD state:
  - `mem_addr` = latched fill address and `mem_rd`=1 for all LAT cycles.
  - `mem_rdata` is sampled into `data_to_cache` at the edge ending the last RD cycle.
  - Then go to RESP.
- RESP state: the granted cache's ready is 1, the other ready is 0, then go to IDLE.
- `data_to_cache` holds its value until the next capture.
- `dcache_wb` without `dcache_req` is ignored.
- Reset values: every output is 0, state is IDLE, `starve_cnt` is 0, and the latches are 0.
- Reset mid-access abandons the access. No ready or ack is issued for it, and the requester must re-request.

## Timing

- All outputs are registered and decoded from state.
- Fill latency: request seen at edge E grants; RD occupies cycles E+1..E+LAT; ready is high in cycle E+LAT+1.
- Fill with writeback: WB occupies E+1..E+LAT; RD occupies E+LAT+1..E+2LAT; ready is high in cycle E+2LAT+1.
- Handshake:
  - The requester drops `req` in the cycle after ready is high.
  - IDLE always lasts at least one cycle, so a completed request is never re-granted.
- Throughput: one access per LAT+2 cycles (2·LAT+2 cycles with writeback).
- Requests asserted in non-IDLE states wait and are not lost.

## Structure

- Package `mem_arb_pkg` contains:
  - State enum `{IDLE, WB, RD, RESP}`.
  - Requester enum `{REQ_I, REQ_D}`.
  - Default ADDR_W/LINE_W localparams.
- Sub-module `mem_access_timer`:
  - Down counter loaded with LAT-1 on phase entry.
  - Outputs `first` and `last` flags.
  - Reused for both the WB and RD phases.

## Test plan

- Lone icache req, addr 0x00010, LAT=4, mem_rdata=0xA5…A5:
  - `mem_rd` is high cycles 1–4 with `mem_addr`=0x00010.
  - `icache_ready` pulses in cycle 5 with `data_to_cache`=0xA5…A5.
  - `dcache_ready` stays 0.
- Dcache req with wb (wb_addr 0x00200, data 0x1234, fill addr 0x00300):
  - `mem_wr` is 1 only in cycle 1 with `mem_addr`=0x00200.
  - `dcache_wb_ack` pulses in cycle 4.
  - `mem_rd` is high cycles 5–8 with `mem_addr`=0x00300.
  - `dcache_ready` pulses in cycle 9.
- Both reqs held continuously (re-raised after each ready), STARVE_MAX=4: grant order is D,D,D,D,I,D,D,D,D,I.
- `icache_addr` changed mid-RD from 0x00010 to 0x00020: `mem_addr` stays 0x00010 for the whole phase.
- Reset asserted in RD cycle 2: the next cycle has every output 0 and `busy`=0, and no ready pulse follows.
- `dcache_wb`=1 with `dcache_req`=0: arbiter stays in IDLE and `mem_wr` stays 0.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and default widths for the cache/RAM port arbiter.
package mem_arb_pkg;

  localparam int unsigned ADDR_W_DEF = 20;
  localparam int unsigned LINE_W_DEF = 128;

  typedef enum logic [1:0] {IDLE, WB, RD, RESP} state_t;
  typedef enum logic {REQ_I, REQ_D} req_id_t;

endpackage

// File: rtl/mem_access_timer.sv
// Phase timer: counts down LAT cycles from load, flags first and last cycle of a phase.
module mem_access_timer #(
  parameter int unsigned LAT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic load,
  output logic first,
  output logic last
);

  localparam int unsigned CNT_W = (LAT > 1) ? $clog2(LAT) : 1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_first;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt   <= '0;
      r_first <= 1'b0;
    end else if (load) begin
      r_cnt   <= CNT_W'(LAT - 1);
      r_first <= 1'b1;
    end else begin
      r_first <= 1'b0;
      if (r_cnt != '0) r_cnt <= r_cnt - 1'b1;
    end
  end

  assign first = r_first;
  assign last  = (r_cnt == '0);

endmodule

// File: rtl/mem_req_arbiter.sv
// Serialises icache/dcache line fills (with optional dcache victim writeback) onto one RAM port.
module mem_req_arbiter
  import mem_arb_pkg::*;
#(
  parameter int unsigned ADDR_W     = ADDR_W_DEF,
  parameter int unsigned LINE_W     = LINE_W_DEF,
  parameter int unsigned LAT        = 4,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              icache_req,
  input  logic [ADDR_W-1:0] icache_addr,
  input  logic              dcache_req,
  input  logic [ADDR_W-1:0] dcache_addr,
  input  logic              dcache_wb,
  input  logic [ADDR_W-1:0] dcache_wb_addr,
  input  logic [LINE_W-1:0] dcache_wb_data,
  input  logic [LINE_W-1:0] mem_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [LINE_W-1:0] mem_wdata,
  output logic [LINE_W-1:0] data_to_cache,
  output logic              icache_ready,
  output logic              dcache_ready,
  output logic              dcache_wb_ack,
  output logic              busy
);

  localparam int unsigned SW = $clog2(STARVE_MAX + 1);

  state_t            r_state;
  state_t            w_next;
  req_id_t           r_gnt;
  req_id_t           w_gnt;
  logic              w_gnt_valid;
  logic              w_load;
  logic              w_first;
  logic              w_last;
  logic [SW-1:0]     r_starve;
  logic [ADDR_W-1:0] r_fill_addr;
  logic [ADDR_W-1:0] r_wb_addr;
  logic [LINE_W-1:0] r_wb_data;
  logic [LINE_W-1:0] r_data;

  mem_access_timer #(.LAT(LAT)) u_timer (
    .clk   (clk),
    .reset (reset),
    .load  (w_load),
    .first (w_first),
    .last  (w_last)
  );

  always_comb begin
    w_next      = r_state;
    w_gnt_valid = 1'b0;
    w_gnt       = REQ_D;
    case (r_state)
      IDLE: begin
        if (icache_req && dcache_req) begin
          w_gnt_valid = 1'b1;
          w_gnt       = (r_starve == SW'(STARVE_MAX)) ? REQ_I : REQ_D;
        end else if (dcache_req) begin
          w_gnt_valid = 1'b1;
          w_gnt       = REQ_D;
        end else if (icache_req) begin
          w_gnt_valid = 1'b1;
          w_gnt       = REQ_I;
        end
        if (w_gnt_valid) w_next = (w_gnt == REQ_D && dcache_wb) ? WB : RD;
      end
      WB:      if (w_last) w_next = RD;
      RD:      if (w_last) w_next = RESP;
      RESP:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
    // Timer reloads whenever a WB or RD phase is entered, including WB->RD.
    w_load = ((w_next == WB) && (r_state != WB)) || ((w_next == RD) && (r_state != RD));
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= IDLE;
      r_gnt       <= REQ_I;
      r_starve    <= '0;
      r_fill_addr <= '0;
      r_wb_addr   <= '0;
      r_wb_data   <= '0;
      r_data      <= '0;
    end else begin
      r_state <= w_next;
      if (w_gnt_valid) begin
        r_gnt       <= w_gnt;
        r_fill_addr <= (w_gnt == REQ_I) ? icache_addr : dcache_addr;
        r_wb_addr   <= dcache_wb_addr;
        r_wb_data   <= dcache_wb_data;
        if (w_gnt == REQ_I)
          r_starve <= '0;
        else if (icache_req && (r_starve != SW'(STARVE_MAX)))
          r_starve <= r_starve + 1'b1;
      end
      if ((r_state == RD) && w_last) r_data <= mem_rdata;
    end
  end

  assign mem_addr      = (r_state == WB) ? r_wb_addr :
                         (r_state == RD) ? r_fill_addr : '0;
  assign mem_wdata     = (r_state == WB) ? r_wb_data : '0;
  assign mem_rd        = (r_state == RD);
  assign mem_wr        = (r_state == WB) && w_first;
  assign dcache_wb_ack = (r_state == WB) && w_last;
  assign icache_ready  = (r_state == RESP) && (r_gnt == REQ_I);
  assign dcache_ready  = (r_state == RESP) && (r_gnt == REQ_D);
  assign busy          = (r_state != IDLE);
  assign data_to_cache = r_data;

endmodule
